pcie_lane_tx_ser: RTL and testbench
===================================

// Module: pcie_lane_tx_ser
// PURPOSE
//   Per-lane PCIe Gen1 transmit back end: accepts one 8-bit symbol (data or K) per handshake,
//   8b/10b-encodes it with running disparity, and shifts it out LSB ('a') first, one bit per clk,
//   as the differential pair tx_p/tx_n that lands on the pcie_if lane. Instantiated once per lane.
// PARAMETERS
//   INIT_RD   1'b0   running disparity after reset (0 = RD-, 1 = RD+)
// PORTS
//   clk        in   1  bit clock; one serial bit per cycle
//   rst        in   1  synchronous, active-high reset
//   tx_data    in   8  symbol byte (HGF_EDCBA)
//   tx_k       in   1  1 = control (K) symbol
//   tx_valid   in   1  symbol offered
//   tx_ready   out  1  block accepts symbol when tx_valid && tx_ready
//   tx_eidle   in   1  request electrical idle
//   tx_p       out  1  serial positive leg
//   tx_n       out  1  serial negative leg (~tx_p while active)
//   sym_err    out  1  1-cycle pulse: illegal K code accepted
//   underrun   out  1  1-cycle pulse: symbol ended with no next symbol, not in eidle
//   rd_out     out  1  current running disparity
// BEHAVIOUR
//   - FSM: EIDLE (reset state) -> SHIFT on accept; SHIFT -> SHIFT on accept at bit_cnt==9;
//     SHIFT -> EIDLE at bit_cnt==9 with no accept (tx_eidle high, or underrun pulse if low).
//   - bit_cnt 0..9 in SHIFT; wraps 9->0 on back-to-back accept; no bubble between symbols.
//   - tx_ready = !rst && !tx_eidle && (state==EIDLE || bit_cnt==9); combinational on state/tx_eidle.
//   - Latency: accept at edge N -> bit 'a' on tx_p after edge N (cycle N+1); order a b c d e i f g h j.
//   - EIDLE: tx_p = tx_n = 0. SHIFT: tx_p = shreg[0], tx_n = ~shreg[0]. All registered.
//   - tx_eidle mid-symbol: current symbol completes all 10 bits, then EIDLE; RD preserved.
//   - Encode at accept: standard 5b/6b + 3b/4b tables, 6b sub-block uses RD in, 4b uses RD after 6b;
//     D.x.A7 used for x in {17,18,20} at RD- and {11,13,14} at RD+; rd_out updated at accept.
//   - Legal K: K28.0..K28.7, K23.7, K27.7, K29.7, K30.7. Illegal K (tx_k with other byte):
//     accepted, K30.7 (EDB) transmitted instead, sym_err pulses the cycle after accept.
//   - Reset values: tx_p=0, tx_n=0, tx_ready=0 (while rst), sym_err=0, underrun=0, rd_out=INIT_RD,
//     state=EIDLE, bit_cnt=0. Reset mid-symbol aborts the symbol; next edge drives idle outputs.
// CONFIGURATION
//   PCIE_TX_SCRAMBLE_EN defined: 16-bit LFSR G(x)=x^16+x^5+x^4+x^3+1, seed 16'hFFFF.
//     D symbols XORed with LFSR byte before encode; K symbols never scrambled.
//     Accepted COM (K28.5) reloads seed; SKP (K28.0) does not advance LFSR; every other accepted
//     symbol advances it 8 bit-times. Reset reloads seed.
//   Not defined: tx_data encoded as presented; no LFSR flops exist.
// STRUCTURE
//   pcie_phy_pkg: K_COM=8'hBC, K_SKP=8'h1C, K_IDL=8'h7C, K_EDB=8'hFE, LFSR_SEED=16'hFFFF,
//     SYM_BITS=10, typedef enum {TX_EIDLE, TX_SHIFT} tx_ser_state_e.
//   Sub-module pcie_enc_8b10b (combinational): data, k, rd_in -> code[9:0], rd_out, k_err.
//   Top holds FSM, bit counter, 10-bit shift register, RD flop, optional scrambler.
// TESTING
//   1 reset, send D0.0 (8'h00,k=0) at RD- -> bits 1,0,0,1,1,1,0,1,0,0; rd_out stays 0.
//   2 K28.5 twice from RD- -> 0011111010 then 1100000101 (abcdeifghj); rd_out 0->1->0.
//   3 three symbols, tx_valid held -> 30 contiguous bits, tx_ready high only at bit_cnt==9.
//   4 illegal K (8'h00,k=1) at RD- -> sym_err one pulse, 0111101000 (K30.7) on line.
//   5 tx_eidle high at bit 4 -> bits 5..9 sent, then tx_p=tx_n=0, tx_ready=0; drop -> ready next cycle.
//   6 PCIE_TX_SCRAMBLE_EN: COM then D 8'h00 x3 -> encoded bytes 8'hFF, 8'h17, 8'hC0;
//     SKP inserted between does not shift sequence. Without macro -> 8'h00 x3 encoded.
//   7 rst asserted mid-symbol -> next edge tx_p=tx_n=0, rd_out=INIT_RD; no underrun pulse.

Source files
------------

// File: rtl/pcie_lane_tx_ser_pkg.sv
// pcie_phy_pkg: lane transmit constants, serializer state type and
// Gen1 scrambler LFSR helpers (used when PCIE_TX_SCRAMBLE_EN is defined).
package pcie_phy_pkg;

  localparam logic [7:0]  K_COM     = 8'hBC;
  localparam logic [7:0]  K_SKP     = 8'h1C;
  localparam logic [7:0]  K_IDL     = 8'h7C;
  localparam logic [7:0]  K_EDB     = 8'hFE;
  localparam logic [15:0] LFSR_SEED = 16'hFFFF;
  localparam int          SYM_BITS  = 10;

  typedef enum logic {TX_EIDLE, TX_SHIFT} tx_ser_state_e;

  // One bit-time of x^16+x^5+x^4+x^3+1, output tap at bit 15
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:5], s[4:2] ^ {3{s[15]}}, s[1:0], s[15]};
  endfunction

  function automatic logic [7:0] lfsr_mask(input logic [15:0] s);
    logic [15:0] t;
    logic [7:0]  m;
    t = s;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      m[i] = t[15];
      t    = lfsr_step(t);
    end
    return m;
  endfunction

  function automatic logic [15:0] lfsr_next8(input logic [15:0] s);
    logic [15:0] t;
    t = s;
    for (int i = 0; i < 8; i++) t = lfsr_step(t);
    return t;
  endfunction

endpackage

// File: rtl/pcie_lane_tx_ser_if.sv
// pcie_lane_tx_ser_if: symbol handshake from the link layer into one
// lane serializer, plus the electrical-idle request.
interface pcie_lane_tx_ser_if;
  logic [7:0] tx_data;
  logic       tx_k;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_eidle;

  modport master (
    output tx_data, tx_k, tx_valid, tx_eidle,
    input  tx_ready
  );

  modport slave (
    input  tx_data, tx_k, tx_valid, tx_eidle,
    output tx_ready
  );
endinterface

// File: rtl/pcie_enc_8b10b.sv
// pcie_enc_8b10b: combinational 8b/10b encoder, code[0]='a' .. code[9]='j'.
// Illegal K inputs are replaced by K30.7 (EDB) and flagged on k_err.
import pcie_phy_pkg::*;

module pcie_enc_8b10b (
  input  logic [7:0] data,
  input  logic       k,
  input  logic       rd_in,
  output logic [9:0] code,
  output logic       rd_out,
  output logic       k_err
);

  // abcdei as seen from RD-
  function automatic logic [5:0] tbl6(input logic [4:0] x);
    logic [5:0] r;
    unique case (x)
      5'd0:  r = 6'b100111;  5'd1:  r = 6'b011101;
      5'd2:  r = 6'b101101;  5'd3:  r = 6'b110001;
      5'd4:  r = 6'b110101;  5'd5:  r = 6'b101001;
      5'd6:  r = 6'b011001;  5'd7:  r = 6'b111000;
      5'd8:  r = 6'b111001;  5'd9:  r = 6'b100101;
      5'd10: r = 6'b010101;  5'd11: r = 6'b110100;
      5'd12: r = 6'b001101;  5'd13: r = 6'b101100;
      5'd14: r = 6'b011100;  5'd15: r = 6'b010111;
      5'd16: r = 6'b011011;  5'd17: r = 6'b100011;
      5'd18: r = 6'b010011;  5'd19: r = 6'b110010;
      5'd20: r = 6'b001011;  5'd21: r = 6'b101010;
      5'd22: r = 6'b011010;  5'd23: r = 6'b111010;
      5'd24: r = 6'b110011;  5'd25: r = 6'b100110;
      5'd26: r = 6'b010110;  5'd27: r = 6'b110110;
      5'd28: r = 6'b001110;  5'd29: r = 6'b101110;
      5'd30: r = 6'b011110;  5'd31: r = 6'b101011;
      default: r = 6'b000000;
    endcase
    return r;
  endfunction

  // fghj for data at RD-
  function automatic logic [3:0] tbl4d(input logic [2:0] y);
    logic [3:0] r;
    unique case (y)
      3'd0: r = 4'b1011;  3'd1: r = 4'b1001;
      3'd2: r = 4'b0101;  3'd3: r = 4'b1100;
      3'd4: r = 4'b1101;  3'd5: r = 4'b1010;
      3'd6: r = 4'b0110;  3'd7: r = 4'b1110;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // fghj for K codes at RD+ (after the 6b block); RD- is the complement
  function automatic logic [3:0] tbl4k(input logic [2:0] y);
    logic [3:0] r;
    unique case (y)
      3'd0: r = 4'b0100;  3'd1: r = 4'b1001;
      3'd2: r = 4'b0101;  3'd3: r = 4'b0011;
      3'd4: r = 4'b0010;  3'd5: r = 4'b1010;
      3'd6: r = 4'b0110;  3'd7: r = 4'b1000;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  logic [7:0] d;
  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] s6m, s6;
  logic [3:0] s4m, s4;
  logic       rd6, a7, legal;

  always_comb begin
    legal = (data[4:0] == 5'd28) ||
            (data[7:5] == 3'd7 &&
             (data[4:0] == 5'd23 || data[4:0] == 5'd27 ||
              data[4:0] == 5'd29 || data[4:0] == 5'd30));
    k_err = k && !legal;
    d     = k_err ? K_EDB : data;
    x     = d[4:0];
    y     = d[7:5];

    s6m = (k && x == 5'd28) ? 6'b001111 : tbl6(x);
    s6  = s6m;
    rd6 = rd_in;
    if ($countones(s6m) != 3) begin
      s6  = rd_in ? ~s6m : s6m;
      rd6 = ~rd_in;
    end else if (rd_in && x == 5'd7 && !k) begin
      s6 = 6'b000111;
    end

    a7 = y == 3'd7 &&
         ((!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
          (rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
    s4m = a7 ? 4'b0111 : tbl4d(y);
    s4  = s4m;
    if (k)
      s4 = rd6 ? tbl4k(y) : ~tbl4k(y);
    else if (rd6 && !(y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6))
      s4 = ~s4m;

    rd_out = rd6 ^ ($countones(s4) != 2);
    code   = {s4[0], s4[1], s4[2], s4[3],
              s6[0], s6[1], s6[2], s6[3], s6[4], s6[5]};
  end

endmodule

// File: rtl/pcie_lane_tx_ser.sv
// pcie_lane_tx_ser: per-lane Gen1 TX back end (8b/10b + serializer).
// Optional scrambler enabled by defining PCIE_TX_SCRAMBLE_EN.
import pcie_phy_pkg::*;

module pcie_lane_tx_ser #(
  parameter logic INIT_RD = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  pcie_lane_tx_ser_if.slave  tx,
  output logic               tx_p,
  output logic               tx_n,
  output logic               sym_err,
  output logic               underrun,
  output logic               rd_out
);

  tx_ser_state_e state, state_nx;
  logic [3:0]    bit_cnt, cnt_nx;
  logic [9:0]    shreg, sh_nx;
  logic          p_nx, n_nx, rd_nx, err_nx, und_nx;
  logic          last, accept;
  logic [7:0]    enc_data;
  logic [9:0]    code;
  logic          enc_rd, k_err;

  assign last = (bit_cnt == 4'(SYM_BITS - 1));
  assign tx.tx_ready = !rst && !tx.tx_eidle &&
                       (state == TX_EIDLE || last);
  assign accept = tx.tx_valid && tx.tx_ready;

`ifdef PCIE_TX_SCRAMBLE_EN
  logic [15:0] lfsr, lfsr_nx;

  assign enc_data = tx.tx_k ? tx.tx_data
                            : tx.tx_data ^ lfsr_mask(lfsr);

  always_comb begin
    lfsr_nx = lfsr;
    if (accept) begin
      if (tx.tx_k && tx.tx_data == K_COM)
        lfsr_nx = LFSR_SEED;
      else if (!(tx.tx_k && tx.tx_data == K_SKP))
        lfsr_nx = lfsr_next8(lfsr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= lfsr_nx;
  end
`else
  assign enc_data = tx.tx_data;
`endif

  pcie_enc_8b10b u_enc (
    .data   (enc_data),
    .k      (tx.tx_k),
    .rd_in  (rd_out),
    .code   (code),
    .rd_out (enc_rd),
    .k_err  (k_err)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = bit_cnt;
    sh_nx    = shreg;
    p_nx     = tx_p;
    n_nx     = tx_n;
    rd_nx    = rd_out;
    err_nx   = 1'b0;
    und_nx   = 1'b0;
    if (accept) begin
      state_nx = TX_SHIFT;
      cnt_nx   = '0;
      sh_nx    = code;
      p_nx     = code[0];
      n_nx     = ~code[0];
      rd_nx    = enc_rd;
      err_nx   = k_err;
    end else begin
      unique case (state)
        TX_EIDLE: begin
          p_nx = 1'b0;
          n_nx = 1'b0;
        end
        TX_SHIFT: begin
          if (last) begin
            state_nx = TX_EIDLE;
            cnt_nx   = '0;
            p_nx     = 1'b0;
            n_nx     = 1'b0;
            und_nx   = !tx.tx_eidle;
          end else begin
            cnt_nx = bit_cnt + 4'd1;
            sh_nx  = {1'b0, shreg[9:1]};
            p_nx   = shreg[1];
            n_nx   = ~shreg[1];
          end
        end
        default: state_nx = TX_EIDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= TX_EIDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_p     <= 1'b0;
      tx_n     <= 1'b0;
      rd_out   <= INIT_RD;
      sym_err  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_nx;
      bit_cnt  <= cnt_nx;
      shreg    <= sh_nx;
      tx_p     <= p_nx;
      tx_n     <= n_nx;
      rd_out   <= rd_nx;
      sym_err  <= err_nx;
      underrun <= und_nx;
    end
  end

endmodule

// File: tb/tb_pcie_lane_tx_ser.sv
// tb_pcie_lane_tx_ser: directed checks of encoding, serial order,
// handshake, eidle, illegal K, underrun, reset abort and scrambling.
module tb_pcie_lane_tx_ser;

  logic clk = 1'b0;
  logic rst;
  logic tx_p, tx_n, sym_err, underrun, rd_out;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  pcie_lane_tx_ser_if bus ();

  pcie_lane_tx_ser #(.INIT_RD(1'b0)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx       (bus),
    .tx_p     (tx_p),
    .tx_n     (tx_n),
    .sym_err  (sym_err),
    .underrun (underrun),
    .rd_out   (rd_out)
  );

`ifdef PCIE_TX_SCRAMBLE_EN
  localparam logic [9:0] E6_D1 = 10'b0101001110;
  localparam logic [9:0] E6_D2 = 10'b0001011011;
  localparam logic [9:0] E6_D3 = 10'b0110000110;
  localparam logic       E6_RD = 1'b0;
`else
  localparam logic [9:0] E6_D1 = 10'b0110001011;
  localparam logic [9:0] E6_D2 = 10'b0110001011;
  localparam logic [9:0] E6_D3 = 10'b0110001011;
  localparam logic       E6_RD = 1'b1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic collect(output logic [9:0] bits, output int errs,
                         output logic ok);
    bits = '0;
    errs = 0;
    ok   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bits = {bits[8:0], tx_p};
      if (sym_err) errs++;
      if (tx_n !== ~tx_p) ok = 1'b0;
      if (bus.tx_ready !== (i == 9 && !bus.tx_eidle)) ok = 1'b0;
    end
  endtask

  task automatic sym(input logic [7:0] d, input logic k,
                     input logic lst, input string tag,
                     input logic [9:0] exp, input int exp_err);
    logic [9:0] b;
    int         e;
    logic       ok;
    bus.tx_data  = d;
    bus.tx_k     = k;
    bus.tx_valid = 1'b1;
    #1;
    chk({tag, " ready"}, bus.tx_ready, 1);
    @(posedge clk);
    #1;
    if (lst) bus.tx_valid = 1'b0;
    collect(b, e, ok);
    chk({tag, " bits"}, b, exp);
    chk({tag, " line"}, ok, 1);
    chk({tag, " sym_err"}, e, exp_err);
  endtask

  initial begin
    logic [9:0] b;
    logic       ok;
    int         u;

    rst          = 1'b1;
    bus.tx_data  = 8'h00;
    bus.tx_k     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_eidle = 1'b0;
    idle(3);
    chk("rst tx_p", tx_p, 0);
    chk("rst tx_n", tx_n, 0);
    chk("rst ready", bus.tx_ready, 0);
    chk("rst sym_err", sym_err, 0);
    chk("rst underrun", underrun, 0);
    chk("rst rd", rd_out, 0);
    rst = 1'b0;
    #1;
    chk("idle ready", bus.tx_ready, 1);

    // 1: D0.0 at RD-, then underrun pulse
    sym(8'h00, 1'b0, 1'b1, "t1 D0.0", 10'b1001110100, 0);
    chk("t1 rd", rd_out, 0);
    @(negedge clk);
    chk("t1 underrun", underrun, 1);
    chk("t1 idle p", tx_p, 0);
    chk("t1 idle n", tx_n, 0);
    @(negedge clk);
    chk("t1 underrun end", underrun, 0);

    // 2: K28.5 twice, disparity flips
    sym(K_COM_V(), 1'b1, 1'b0, "t2 com-", 10'b0011111010, 0);
    chk("t2 rd1", rd_out, 1);
    sym(K_COM_V(), 1'b1, 1'b1, "t2 com+", 10'b1100000101, 0);
    chk("t2 rd2", rd_out, 0);
    idle(2);

    // 3: three contiguous symbols, both A7 cases
    sym(8'hB5, 1'b0, 1'b0, "t3 D21.5", 10'b1010101010, 0);
    sym(8'hF1, 1'b0, 1'b0, "t3 D17.7", 10'b1000110111, 0);
    chk("t3 rd mid", rd_out, 1);
    sym(8'hEB, 1'b0, 1'b1, "t3 D11.7", 10'b1101001000, 0);
    chk("t3 rd end", rd_out, 0);
    idle(2);

    // 4: illegal K becomes EDB
    sym(8'h00, 1'b1, 1'b1, "t4 badK", 10'b0111101000, 1);
    chk("t4 rd", rd_out, 0);
    idle(2);

    // 5: eidle raised mid-symbol
    bus.tx_data  = 8'h00;
    bus.tx_k     = 1'b0;
    bus.tx_valid = 1'b1;
    #1;
    chk("t5 ready", bus.tx_ready, 1);
    @(posedge clk);
    b  = '0;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      b = {b[8:0], tx_p};
      if (tx_n !== ~tx_p) ok = 1'b0;
      if (bus.tx_ready !== (i == 9 && !bus.tx_eidle)) ok = 1'b0;
      if (i == 4) bus.tx_eidle = 1'b1;
    end
    chk("t5 bits", b, 10'b1001110100);
    chk("t5 line", ok, 1);
    @(negedge clk);
    chk("t5 eidle p", tx_p, 0);
    chk("t5 eidle n", tx_n, 0);
    chk("t5 eidle ready", bus.tx_ready, 0);
    chk("t5 no underrun", underrun, 0);
    idle(2);
    chk("t5 held p", tx_p, 0);
    chk("t5 rd", rd_out, 0);
    bus.tx_valid = 1'b0;
    bus.tx_eidle = 1'b0;
    #1;
    chk("t5 ready back", bus.tx_ready, 1);
    @(negedge clk);

    // 6: COM, D, SKP, D, D
    sym(K_COM_V(), 1'b1, 1'b0, "t6 com", 10'b0011111010, 0);
    sym(8'h00, 1'b0, 1'b0, "t6 d1", E6_D1, 0);
    sym(8'h1C, 1'b1, 1'b0, "t6 skp", 10'b1100001011, 0);
    sym(8'h00, 1'b0, 1'b0, "t6 d2", E6_D2, 0);
    sym(8'h00, 1'b0, 1'b1, "t6 d3", E6_D3, 0);
    chk("t6 rd", rd_out, E6_RD);
    idle(2);

    // 7: reset aborts a symbol with RD+ pending
`ifdef PCIE_TX_SCRAMBLE_EN
    bus.tx_data = K_COM_V();
    bus.tx_k    = 1'b1;
`else
    bus.tx_data = 8'h00;
    bus.tx_k    = 1'b0;
`endif
    bus.tx_valid = 1'b1;
    #1;
    chk("t7 ready", bus.tx_ready, 1);
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
    idle(3);
    chk("t7 pre p", tx_p, 1);
    chk("t7 pre rd", rd_out, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t7 p", tx_p, 0);
    chk("t7 n", tx_n, 0);
    chk("t7 rd", rd_out, 0);
    chk("t7 ready", bus.tx_ready, 0);
    u = 0;
    for (int i = 0; i < 4; i++) begin
      if (underrun) u++;
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    if (underrun) u++;
    chk("t7 underrun", u, 0);
    chk("t7 ready after", bus.tx_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  function automatic logic [7:0] K_COM_V();
    return 8'hBC;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

endmodule
